scene_mixer: RTL and testbench

SCENE_MIXER -- requirements
Module: scene_mixer

---
 rtl/scene_mixer_pkg.sv | 16 +
 rtl/scene_mixer_layer_priority_mux.sv | 27 ++
 rtl/scene_mixer.sv | 137 +++++++++++++
 tb/tb_scene_mixer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/scene_mixer_pkg.sv
// scene_mixer_pkg: shared definitions for the scene mixer slice.
//   game_state_t  - game FSM encodings as seen on the game_state port
//   H_ACTIVE_DEF  - default visible width in pixels
//   V_ACTIVE_DEF  - default visible height in lines
package scene_mixer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } game_state_t;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

endpackage

// File: rtl/scene_mixer_layer_priority_mux.sv
// layer_priority_mux: combinational priority select of sprite layers.
//   px      in  NUM_LAYERS  per-layer pixel bits
//   visible in  NUM_LAYERS  layers allowed to show in the current game state
//   color   out 4           intensity of the lowest-index visible set layer, else 0
module layer_priority_mux #(
  parameter int unsigned                 NUM_LAYERS  = 8,
  parameter logic [4*NUM_LAYERS-1:0]     LAYER_COLOR = {NUM_LAYERS{4'hF}}
) (
  input  logic [NUM_LAYERS-1:0] px,
  input  logic [NUM_LAYERS-1:0] visible,
  output logic [3:0]            color
);

  logic found;

  always_comb begin
    color = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (!found && px[i] && visible[i]) begin
        color = LAYER_COLOR[4*i +: 4];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scene_mixer.sv
// scene_mixer: mixes 1-bit sprite layers into a 4-bit pixel and runs the
// game state machine (IDLE/RUN/OVER) with sticky collision tracking.
//   clk        in  1           pixel clock
//   reset      in  1           asynchronous active-high reset
//   haddress   in  10          horizontal scan position
//   vaddress   in  10          vertical scan position
//   layer_px   in  NUM_LAYERS  per-layer pixel bits at the scan position
//   start      in  1           player buttons (level; rising edge used)
//   restart    in  1           return to title (level)
//   color      out 4           registered mixed intensity
//   game_state out 2           0=IDLE 1=RUN 2=OVER
//   collide    out 1           sticky collision flag
//   hit_mask   out NUM_LAYERS  hazard layers hit since last RUN entry
//   frames     out 16          completed frames in current RUN, saturating
module scene_mixer
  import scene_mixer_pkg::*;
#(
  parameter int unsigned             NUM_LAYERS  = 8,
  parameter int unsigned             PLAYER_IDX  = 0,
  parameter logic [NUM_LAYERS-1:0]   HAZARD_MASK = ~(NUM_LAYERS'(1) << PLAYER_IDX),
  parameter int unsigned             BANNER_IDX  = NUM_LAYERS - 1,
  parameter logic [4*NUM_LAYERS-1:0] LAYER_COLOR = {NUM_LAYERS{4'hF}},
  parameter int unsigned             H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned             V_ACTIVE    = V_ACTIVE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            haddress,
  input  logic [9:0]            vaddress,
  input  logic [NUM_LAYERS-1:0] layer_px,
  input  logic                  start,
  input  logic                  restart,
  output logic [3:0]            color,
  output logic [1:0]            game_state,
  output logic                  collide,
  output logic [NUM_LAYERS-1:0] hit_mask,
  output logic [15:0]           frames
);

  // Limits folded to scan-address width so every compare is 10-bit.
  localparam logic [9:0] H_LIM  = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM  = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);

  game_state_t           state;
  logic                  start_q;
  logic                  start_rise;
  logic                  active;
  logic                  frame_end;
  logic                  hit;
  logic [NUM_LAYERS-1:0] visible;
  logic [3:0]            mux_color;

  assign start_rise = start & ~start_q;
  assign active     = (haddress < H_LIM) && (vaddress < V_LIM);
  assign frame_end  = (haddress == H_LAST) && (vaddress == V_LAST);
  assign hit        = (state == ST_RUN) && active && layer_px[PLAYER_IDX]
                      && (|(layer_px & HAZARD_MASK));

  always_comb begin
    visible = '0;
    unique case (state)
      ST_IDLE: visible[BANNER_IDX] = 1'b1;
      ST_RUN: begin
        visible             = '1;
        visible[BANNER_IDX] = 1'b0;
      end
      ST_OVER: begin
        visible[PLAYER_IDX] = 1'b1;
        visible[BANNER_IDX] = 1'b1;
      end
      default: visible = '0;
    endcase
  end

  layer_priority_mux #(
    .NUM_LAYERS  (NUM_LAYERS),
    .LAYER_COLOR (LAYER_COLOR)
  ) u_mux (
    .px      (layer_px),
    .visible (visible),
    .color   (mux_color)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      start_q  <= 1'b0;
      color    <= '0;
      collide  <= 1'b0;
      hit_mask <= '0;
      frames   <= '0;
    end else begin
      start_q <= start;
      color   <= active ? mux_color : 4'h0;
      unique case (state)
        ST_IDLE: begin
          if (!restart && start_rise) begin
            state    <= ST_RUN;
            collide  <= 1'b0;
            hit_mask <= '0;
            frames   <= '0;
          end
        end
        ST_RUN: begin
          if (hit) begin
            collide  <= 1'b1;
            hit_mask <= hit_mask | (layer_px & HAZARD_MASK);
          end
          // A hit on the last pixel itself still ends the run this frame.
          if (frame_end) begin
            if (collide || hit) begin
              state <= ST_OVER;
            end else if (frames != 16'hFFFF) begin
              frames <= frames + 16'd1;
            end
          end
        end
        ST_OVER: begin
          if (restart) begin
            state <= ST_IDLE;
          end else if (start_rise) begin
            state    <= ST_RUN;
            collide  <= 1'b0;
            hit_mask <= '0;
            frames   <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_scene_mixer.sv
module tb_scene_mixer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] haddress;
  logic [9:0] vaddress;
  logic [7:0] layer_px;
  logic       start;
  logic       restart;
  logic [3:0] color;
  logic [1:0] game_state;
  logic       collide;
  logic [7:0] hit_mask;
  logic [15:0] frames;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Layer i shows intensity i+1.
  scene_mixer #(
    .NUM_LAYERS  (8),
    .LAYER_COLOR (32'h8765_4321)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .haddress   (haddress),
    .vaddress   (vaddress),
    .layer_px   (layer_px),
    .start      (start),
    .restart    (restart),
    .color      (color),
    .game_state (game_state),
    .collide    (collide),
    .hit_mask   (hit_mask),
    .frames     (frames)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic [7:0] px);
    haddress = h;
    vaddress = v;
    layer_px = px;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    restart = 1'b0;
    drive(10'd700, 10'd500, 8'h00);
    tick();
    check("rst_state", 32'(game_state), 32'd0);
    check("rst_color", 32'(color), 32'd0);
    check("rst_collide", 32'(collide), 32'd0);
    check("rst_hitmask", 32'(hit_mask), 32'd0);
    check("rst_frames", 32'(frames), 32'd0);

    reset = 1'b0;
    tick();
    // IDLE: only banner visible
    drive(10'd100, 10'd100, 8'b1000_0110);
    tick();
    check("idle_color_banner", 32'(color), 32'h8);
    check("idle_state", 32'(game_state), 32'd0);

    start = 1'b1;
    tick();
    check("start_run", 32'(game_state), 32'd1);
    check("start_frames", 32'(frames), 32'd0);
    check("start_collide", 32'(collide), 32'd0);
    start = 1'b0;

    // RUN: banner hidden, lowest visible set layer is 1
    drive(10'd100, 10'd100, 8'b1000_0110);
    tick();
    check("run_color_l1", 32'(color), 32'h2);
    check("run_no_collide_noplayer", 32'(collide), 32'd0);

    // Outside active area: no color, no sampling
    drive(10'd650, 10'd100, 8'b0000_0001);
    tick();
    check("out_h_color", 32'(color), 32'd0);
    check("out_h_collide", 32'(collide), 32'd0);
    drive(10'd640, 10'd100, 8'b0000_0011);
    tick();
    check("h640_collide", 32'(collide), 32'd0);
    drive(10'd100, 10'd480, 8'b0000_0011);
    tick();
    check("v480_collide", 32'(collide), 32'd0);
    check("v480_color", 32'(color), 32'd0);
    drive(10'd639, 10'd100, 8'b0000_0100);
    tick();
    check("h639_color", 32'(color), 32'h3);

    // Three clean frame ends
    drive(10'd639, 10'd479, 8'h00);
    tick(); tick(); tick();
    check("frames3", 32'(frames), 32'd3);
    check("frames3_state", 32'(game_state), 32'd1);

    // Collision
    drive(10'd100, 10'd100, 8'b0000_0011);
    tick();
    check("hit_collide", 32'(collide), 32'd1);
    check("hit_mask", 32'(hit_mask), 32'h02);
    check("hit_color", 32'(color), 32'h1);
    check("hit_state_run", 32'(game_state), 32'd1);
    restart = 1'b1; // ignored in RUN
    drive(10'd10, 10'd10, 8'h00);
    tick();
    check("run_ignores_restart", 32'(game_state), 32'd1);
    restart = 1'b0;
    drive(10'd639, 10'd479, 8'h00);
    tick();
    check("over_state", 32'(game_state), 32'd2);
    check("over_frames_frozen", 32'(frames), 32'd3);

    // OVER: player and banner visible; no sampling
    drive(10'd100, 10'd100, 8'b1000_0110);
    tick();
    check("over_color_banner", 32'(color), 32'h8);
    drive(10'd100, 10'd100, 8'b1000_1101);
    tick();
    check("over_color_player", 32'(color), 32'h1);
    check("over_hitmask_hold", 32'(hit_mask), 32'h02);
    check("over_collide_hold", 32'(collide), 32'd1);

    // restart wins over start edge
    restart = 1'b1;
    start = 1'b1;
    tick();
    check("restart_wins", 32'(game_state), 32'd0);
    check("idle_collide_sticky", 32'(collide), 32'd1);
    restart = 1'b0;
    tick(); // start still high: no new edge
    check("held_start_no_edge", 32'(game_state), 32'd0);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    check("rerun_state", 32'(game_state), 32'd1);
    check("rerun_hitmask", 32'(hit_mask), 32'h00);
    check("rerun_collide", 32'(collide), 32'd0);
    check("rerun_frames", 32'(frames), 32'd0);
    start = 1'b0;

    // Saturation: frame end held every cycle
    drive(10'd639, 10'd479, 8'h00);
    repeat (65537) tick();
    check("frames_sat", 32'(frames), 32'hFFFF);
    tick();
    check("frames_sat_hold", 32'(frames), 32'hFFFF);
    check("sat_state", 32'(game_state), 32'd1);

    // Mid-cycle async reset after a collision cycle
    drive(10'd100, 10'd100, 8'b0000_0101);
    tick();
    check("pre_rst_hitmask", 32'(hit_mask), 32'h04);
    #3;
    reset = 1'b1;
    start = 1'b1;
    #1;
    check("async_state", 32'(game_state), 32'd0);
    check("async_color", 32'(color), 32'd0);
    check("async_collide", 32'(collide), 32'd0);
    check("async_hitmask", 32'(hit_mask), 32'd0);
    check("async_frames", 32'(frames), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_start_edge", 32'(game_state), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
